// File: rtl/bcd_entry_2bin.sv
// bcd_entry_2bin: keypad digit entry buffer with BCD-to-binary conversion.
// Digits from the key strobe shift into a BCD buffer that drives the display.
// On start, the buffer is converted to binary using an iterative reverse
// double-dabble, one shift per clock.
// Optional build macro: BACKSPACE_EN. When it is defined, key code BKSP_CODE
// removes the most recently entered digit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready; accepts digits, backspace, clear and start
// SHIFT | conversion running, WIDTH shift/adjust cycles
// DONE  | publish bin_work to bin_out with a one-cycle out_valid pulse
module bcd_entry_2bin #(
    parameter int          MAX_DIGITS = 4,
    parameter int          WIDTH      = 16,
    parameter logic [3:0]  BKSP_CODE  = 4'hC
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              key_valid,
    input  logic [3:0]                        key_bcd,
    input  logic                              clear,
    input  logic                              start,
    output logic                              ready,
    output logic                              out_valid,
    output logic [WIDTH-1:0]                  bin_out,
    output logic [4*MAX_DIGITS-1:0]           entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
    output logic                              ovf
);

    localparam int BW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] LAST_TMR = TW'(WIDTH - 1);
`ifdef BACKSPACE_EN
    localparam logic BKSP_EN = 1'b1;
`else
    localparam logic BKSP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [TW-1:0]     tmr;
    logic [BW-1:0]     bcd_work, bcd_shift;
    logic [WIDTH-1:0]  bin_work, bin_shift;
    logic              key_is_digit;
    logic              take_start;

    // A backspace code that happens to fall in 0-9 is not treated as a digit
    // when backspace is enabled; with it disabled this folds to key_bcd <= 9.
    assign key_is_digit = (key_bcd <= 4'd9) && !(BKSP_EN && (key_bcd == BKSP_CODE));
    assign take_start   = (state == IDLE) && start && !clear;
    assign ready        = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; clear aborts a running conversion but not DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !clear) state_nxt = SHIFT;
            SHIFT: begin
                if (clear)               state_nxt = IDLE;
                else if (tmr == '0)      state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One reverse double-dabble step: shift right, then pull any BCD nibble
    // that reached 8 or more back down by 3.
    always_comb begin
        {bcd_shift, bin_shift} = {bcd_work, bin_work} >> 1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd_shift[4*i +: 4] >= 4'd8)
                bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
        end
    end

    // Conversion datapath and shift down-counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bcd_work  <= '0;
            bin_work  <= '0;
            tmr       <= '0;
            bin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            if (state == DONE)
                bin_out <= bin_work;
            if (take_start) begin
                bcd_work <= entry_bcd;
                bin_work <= '0;
                tmr      <= LAST_TMR;
            end else if (state == SHIFT) begin
                bcd_work <= bcd_shift;
                bin_work <= bin_shift;
                if (tmr != '0)
                    tmr <= tmr - 1'b1;
            end
        end
    end

    // Entry buffer: clear wins in any state; keys only land in IDLE without start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry_bcd <= '0;
            digit_cnt <= '0;
            ovf       <= 1'b0;
        end else if (clear) begin
            entry_bcd <= '0;
            digit_cnt <= '0;
            ovf       <= 1'b0;
        end else if ((state == IDLE) && key_valid && !start) begin
            if (key_is_digit) begin
                if (digit_cnt < FULL_CNT) begin
                    entry_bcd <= (entry_bcd << 4) | BW'(key_bcd);
                    digit_cnt <= digit_cnt + 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
`ifdef BACKSPACE_EN
            else if ((key_bcd == BKSP_CODE) && (digit_cnt != '0)) begin
                entry_bcd <= entry_bcd >> 4;
                digit_cnt <= digit_cnt - 1'b1;
                ovf       <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bcd_entry_2bin.sv
// Testbench for bcd_entry_2bin: table-driven entry/convert vectors plus
// directed sequences for abort, simultaneous events, backspace and reset.
module tb_bcd_entry_2bin;

    logic        clk = 1'b0;
    logic        resetn;
    logic        key_valid;
    logic [3:0]  key_bcd;
    logic        clear;
    logic        start;
    logic        ready;
    logic        out_valid;
    logic [15:0] bin_out;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_cnt;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    bcd_entry_2bin dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_valid (key_valid),
        .key_bcd   (key_bcd),
        .clear     (clear),
        .start     (start),
        .ready     (ready),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .entry_bcd (entry_bcd),
        .digit_cnt (digit_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [19:0] digs;
        logic [15:0] e_entry;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic [15:0] e_bin;
    } vec_t;

    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_bcd   = k;
        tick();
        key_valid = 1'b0;
        key_bcd   = 4'h0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit rdy_bad);
        cyc = 0;
        rdy_bad = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (ready) rdy_bad = 1'b1;
            tick();
            cyc++;
        end
    endtask

    task automatic convert(output int cyc, output bit rdy_bad);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, rdy_bad);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  rdy_bad;
        bit  seen;

        vt[0] = '{4, 20'h12340, 16'h1234, 3'd4, 1'b0, 16'd1234};
        vt[1] = '{5, 20'h99995, 16'h9999, 3'd4, 1'b1, 16'd9999};
        vt[2] = '{0, 20'h00000, 16'h0000, 3'd0, 1'b0, 16'd0};
        vt[3] = '{2, 20'h07000, 16'h0007, 3'd2, 1'b0, 16'd7};
        vt[4] = '{3, 20'h81400, 16'h0814, 3'd3, 1'b0, 16'd814};
        vt[5] = '{4, 20'h05000, 16'h0500, 3'd4, 1'b0, 16'd500};

        resetn = 1'b0;
        key_valid = 1'b0;
        key_bcd = 4'h0;
        clear = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_entry", 32'(entry_bcd), 32'd0);
        chk("rst_cnt", 32'(digit_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        resetn = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            pulse_clear();
            chk("clr_entry", 32'(entry_bcd), 32'd0);
            chk("clr_cnt", 32'(digit_cnt), 32'd0);
            chk("clr_ovf", 32'(ovf), 32'd0);
            for (int k = 0; k < vt[v].n; k++)
                key(vt[v].digs[19-4*k -: 4]);
            chk("vec_entry", 32'(entry_bcd), 32'(vt[v].e_entry));
            chk("vec_cnt", 32'(digit_cnt), 32'(vt[v].e_cnt));
            chk("vec_ovf", 32'(ovf), 32'(vt[v].e_ovf));
            convert(cyc, rdy_bad);
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_latency", 32'(cyc), 32'd17);
            chk("vec_bin", 32'(bin_out), 32'(vt[v].e_bin));
            chk("vec_ready_low", 32'(rdy_bad), 32'd0);
            tick();
            chk("vec_valid_pulse", 32'(out_valid), 32'd0);
            chk("vec_entry_kept", 32'(entry_bcd), 32'(vt[v].e_entry));
        end

        // Abort a conversion with clear part-way through SHIFT.
        pulse_clear();
        key(4'd5);
        key(4'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_entry", 32'(entry_bcd), 32'd0);
        chk("abort_cnt", 32'(digit_cnt), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_bin_kept", 32'(bin_out), 32'd500);

        // Key and start together: key dropped; keys/start during SHIFT ignored.
        key(4'd4);
        key(4'd2);
        key_valid = 1'b1;
        key_bcd = 4'd3;
        start = 1'b1;
        tick();
        key_valid = 1'b0;
        start = 1'b0;
        key(4'd7);
        key_valid = 1'b1;
        key_bcd = 4'd9;
        start = 1'b1;
        tick();
        key_valid = 1'b0;
        start = 1'b0;
        chk("shift_entry_hold", 32'(entry_bcd), 32'h0042);
        wait_done(cyc, rdy_bad);
        chk("ks_valid", 32'(out_valid), 32'd1);
        chk("ks_latency", 32'(cyc), 32'd15);
        chk("ks_bin", 32'(bin_out), 32'd42);
        chk("ks_entry", 32'(entry_bcd), 32'h0042);
        chk("ks_cnt", 32'(digit_cnt), 32'd2);
        tick();
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("ks_no_requeue", 32'(seen), 32'd0);

        // Non-digit codes are ignored.
        pulse_clear();
        key(4'd1);
        key(4'hA);
        key(4'hF);
        key(4'd2);
        chk("nondigit_entry", 32'(entry_bcd), 32'h0012);
        chk("nondigit_cnt", 32'(digit_cnt), 32'd2);

        // Backspace code handling.
        pulse_clear();
        key(4'd8);
        key(4'd1);
        key(4'd4);
        key(4'hC);
`ifdef BACKSPACE_EN
        chk("bksp_entry", 32'(entry_bcd), 32'h0081);
        chk("bksp_cnt", 32'(digit_cnt), 32'd2);
        convert(cyc, rdy_bad);
        chk("bksp_bin", 32'(bin_out), 32'd81);
        pulse_clear();
        key(4'hC);
        chk("bksp_empty_entry", 32'(entry_bcd), 32'd0);
        chk("bksp_empty_cnt", 32'(digit_cnt), 32'd0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("bksp_ovf_set", 32'(ovf), 32'd1);
        key(4'hC);
        chk("bksp_ovf_clr", 32'(ovf), 32'd0);
        chk("bksp_ovf_entry", 32'(entry_bcd), 32'h0123);
`else
        chk("bksp_ignored_entry", 32'(entry_bcd), 32'h0814);
        chk("bksp_ignored_cnt", 32'(digit_cnt), 32'd3);
        convert(cyc, rdy_bad);
        chk("bksp_ignored_bin", 32'(bin_out), 32'd814);
`endif

        // Asynchronous reset in the middle of a conversion.
        pulse_clear();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        chk("pre_rst_ovf", 32'(ovf), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_ready", 32'(ready), 32'd0);
        resetn = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_bin_out", 32'(bin_out), 32'd0);
        chk("arst_entry", 32'(entry_bcd), 32'd0);
        chk("arst_cnt", 32'(digit_cnt), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        #2;
        resetn = 1'b1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("arst_no_valid", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
